// File: rtl/regfile_bypass_sb.sv
// Integer register file with NRD combinational read ports, one write port,
// same-cycle write-to-read bypass and a per-register busy scoreboard.
module regfile_bypass_sb #(
  parameter int XLEN   = 32,
  parameter int NREGS  = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NRD*ADDR_W-1:0] ra,
  output logic [NRD*XLEN-1:0]   rd,
  output logic [NRD-1:0]        rbusy,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     wa,
  input  logic [XLEN-1:0]       wd,
  input  logic                  iss_v,
  input  logic [ADDR_W-1:0]     iss_rd,
  input  logic                  flush,
  output logic                  any_busy
);

  if (NREGS < 2 || (1 << ADDR_W) != NREGS || NRD < 1 || NRD > 4) begin : g_param_err
    $error("regfile_bypass_sb: illegal NREGS/ADDR_W/NRD combination");
  end

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             wr_en;
  logic             iss_en;

  assign wr_en  = we && (wa != '0);
  assign iss_en = iss_v && (iss_rd != '0);

  // Set is applied after clear so a new producer supersedes the retiring one.
  always_comb begin
    busy_nxt = busy;
    if (flush) begin
      busy_nxt = '0;
    end else begin
      if (wr_en)  busy_nxt[wa]     = 1'b0;
      if (iss_en) busy_nxt[iss_rd] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NREGS; k++) regs[k] <= '0;
      busy <= '0;
    end else begin
      if (wr_en) regs[wa] <= wd;
      busy <= busy_nxt;
    end
  end

  assign any_busy = !rst && (|busy);

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [ADDR_W-1:0] a;
    logic              hit;
    logic [XLEN-1:0]   data;

    assign a   = ra[i*ADDR_W +: ADDR_W];
    assign hit = we && (wa == a);

    always_comb begin
      data = '0;
      if (rst || a == '0) data = '0;
      else if (hit)       data = wd;
      else                data = regs[a];
    end

    assign rd[i*XLEN +: XLEN] = data;
    // A register written this cycle is bypassed, so it never stalls the reader.
    assign rbusy[i] = !rst && busy[a] && !hit && (a != '0);
  end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// Directed bench for regfile_bypass_sb: default 2-port instance plus a
// 3-port, 64-bit instance; expectations go through a scoreboard queue.
module tb_regfile_bypass_sb;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // default instance: XLEN=32, NRD=2
  logic [9:0]  ra;
  logic [63:0] rd;
  logic [1:0]  rbusy;
  logic        we, iss_v, flush, any_busy;
  logic [4:0]  wa, iss_rd;
  logic [31:0] wd;

  regfile_bypass_sb dut (
    .clk(clk), .rst(rst), .ra(ra), .rd(rd), .rbusy(rbusy),
    .we(we), .wa(wa), .wd(wd), .iss_v(iss_v), .iss_rd(iss_rd),
    .flush(flush), .any_busy(any_busy)
  );

  // wide instance: XLEN=64, NRD=3
  logic [14:0]  ra3;
  logic [191:0] rd3;
  logic [2:0]   rbusy3;
  logic         we3, iss_v3, flush3, any_busy3;
  logic [4:0]   wa3, iss_rd3;
  logic [63:0]  wd3;

  regfile_bypass_sb #(.XLEN(64), .NREGS(32), .ADDR_W(5), .NRD(3)) dut3 (
    .clk(clk), .rst(rst), .ra(ra3), .rd(rd3), .rbusy(rbusy3),
    .we(we3), .wa(wa3), .wd(wd3), .iss_v(iss_v3), .iss_rd(iss_rd3),
    .flush(flush3), .any_busy(any_busy3)
  );

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];
  int n_total = 0;
  int n_pass  = 0;

  task automatic push(input string tag, input logic [63:0] exp);
    sb_entry_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic chk(input logic [63:0] obs);
    sb_entry_t e;
    n_total++;
    if (sb_q.size() == 0) begin
      $error("FAIL sb_underflow observed=%h expected=<none>", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.exp) n_pass++;
      else $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.exp);
    end
  endtask

  task automatic idle();
    we = 1'b0; wa = '0; wd = '0; iss_v = 1'b0; iss_rd = '0; flush = 1'b0;
    we3 = 1'b0; wa3 = '0; wd3 = '0; iss_v3 = 1'b0; iss_rd3 = '0; flush3 = 1'b0;
  endtask

  initial begin
    idle();
    ra = '0; ra3 = '0;
    rst = 1'b1;
    #12 rst = 1'b0;

    // 1: load reg5 with busy set, then async reset mid-cycle
    @(negedge clk);
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; iss_v = 1'b1; iss_rd = 5'd5;
    @(negedge clk);
    idle(); ra[4:0] = 5'd5;
    push("t1_pre_rd", 64'hDEADBEEF); push("t1_pre_rbusy", 64'd1); push("t1_pre_any", 64'd1);
    #1; chk(rd[31:0]); chk(rbusy[0]); chk(any_busy);
    #1; rst = 1'b1;
    push("t1_rst_rd", 64'd0); push("t1_rst_rbusy", 64'd0); push("t1_rst_any", 64'd0);
    #1; chk(rd[31:0]); chk(rbusy[0]); chk(any_busy);
    @(negedge clk); rst = 1'b0;
    push("t1_post_rd", 64'd0); push("t1_post_rbusy", 64'd0); push("t1_post_any", 64'd0);
    #1; chk(rd[31:0]); chk(rbusy[0]); chk(any_busy);

    // 2: bypass then storage
    @(negedge clk);
    we = 1'b1; wa = 5'd7; wd = 32'h12345678; ra[4:0] = 5'd7;
    push("t2_bypass", 64'h12345678);
    #1; chk(rd[31:0]);
    @(negedge clk); idle();
    push("t2_stored", 64'h12345678);
    #1; chk(rd[31:0]);

    // 3: writes and issues to x0 are ignored
    @(negedge clk);
    we = 1'b1; wa = 5'd0; wd = 32'hFFFFFFFF; iss_v = 1'b1; iss_rd = 5'd0; ra = '0;
    push("t3_rd0_same", 64'd0); push("t3_rbusy_same", 64'd0);
    #1; chk(rd[31:0]); chk(rbusy[0]);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk); idle();
      push("t3_rd0", 64'd0); push("t3_rbusy", 64'd0); push("t3_any", 64'd0);
      #1; chk(rd[31:0]); chk(rbusy[0]); chk(any_busy);
    end

    // 4: issue r3, then writeback clears and bypasses
    @(negedge clk);
    iss_v = 1'b1; iss_rd = 5'd3; ra[4:0] = 5'd3;
    push("t4_issue_cycle_rbusy", 64'd0);
    #1; chk(rbusy[0]);
    @(negedge clk); idle();
    push("t4_rbusy", 64'd1); push("t4_any", 64'd1);
    #1; chk(rbusy[0]); chk(any_busy);
    @(negedge clk);
    we = 1'b1; wa = 5'd3; wd = 32'hA5;
    push("t4_wb_rbusy", 64'd0); push("t4_wb_rd", 64'hA5);
    #1; chk(rbusy[0]); chk(rd[31:0]);
    @(negedge clk); idle();
    push("t4_after_rbusy", 64'd0); push("t4_after_any", 64'd0); push("t4_after_rd", 64'hA5);
    #1; chk(rbusy[0]); chk(any_busy); chk(rd[31:0]);

    // 5: set beats clear on the same register
    @(negedge clk);
    iss_v = 1'b1; iss_rd = 5'd4; ra[9:5] = 5'd4;
    @(negedge clk);
    we = 1'b1; wa = 5'd4; wd = 32'h0000_4444; iss_v = 1'b1; iss_rd = 5'd4;
    push("t5_wb_rbusy1", 64'd0);
    #1; chk(rbusy[1]);
    @(negedge clk); idle();
    push("t5_rbusy1", 64'd1); push("t5_rd1", 64'h4444); push("t5_any", 64'd1);
    #1; chk(rbusy[1]); chk(rd[63:32]); chk(any_busy);

    // 6: busy on 2, 9, 31 then flush with a same-cycle issue
    @(negedge clk); iss_v = 1'b1; iss_rd = 5'd2;
    @(negedge clk); iss_rd = 5'd9;
    @(negedge clk); iss_rd = 5'd31;
    @(negedge clk); idle(); ra[4:0] = 5'd31; ra[9:5] = 5'd9;
    push("t6_rbusy31", 64'd1); push("t6_rbusy9", 64'd1);
    #1; chk(rbusy[0]); chk(rbusy[1]);
    @(negedge clk);
    flush = 1'b1; iss_v = 1'b1; iss_rd = 5'd10;
    @(negedge clk); idle(); ra[4:0] = 5'd10; ra[9:5] = 5'd2;
    push("t6_any", 64'd0); push("t6_rbusy10", 64'd0); push("t6_rbusy2", 64'd0);
    #1; chk(any_busy); chk(rbusy[0]); chk(rbusy[1]);

    // 6b: wide instance, three ports, ra = {1, 2, 1}
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd1; wd3 = 64'h1111_2222_3333_4444;
    @(negedge clk);
    we3 = 1'b1; wa3 = 5'd2; wd3 = 64'hAAAA_BBBB_CCCC_DDDD; iss_v3 = 1'b1; iss_rd3 = 5'd2;
    @(negedge clk); idle();
    ra3 = {5'd1, 5'd2, 5'd1};
    push("t6w_rd0", 64'h1111_2222_3333_4444);
    push("t6w_rd1", 64'hAAAA_BBBB_CCCC_DDDD);
    push("t6w_rd2", 64'h1111_2222_3333_4444);
    push("t6w_rbusy", 64'b010);
    #1; chk(rd3[63:0]); chk(rd3[127:64]); chk(rd3[191:128]); chk({61'd0, rbusy3});
    @(negedge clk);
    flush3 = 1'b1; iss_v3 = 1'b1; iss_rd3 = 5'd10;
    @(negedge clk); idle(); ra3 = {5'd1, 5'd10, 5'd2};
    push("t6w_any", 64'd0); push("t6w_rbusy_after", 64'd0); push("t6w_rd2_after", 64'h1111_2222_3333_4444);
    #1; chk(any_busy3); chk({61'd0, rbusy3}); chk(rd3[191:128]);

    if (sb_q.size() != 0) begin
      n_total++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/regfile_bypass_sb.md
Name: regfile_bypass_sb

Overview:
- Parametrised integer register file for the RISC-V pipeline.
- NRD combinational read ports and one synchronous write port.
- Same-cycle write-to-read bypass, so ID reads see a WB write in the same cycle.
- Per-register busy scoreboard: set at issue, cleared at writeback, so the hazard unit can stall on pending producers without comparing pipeline stages.
- Sits in the ID stage; replaces the fixed 2-port, 32x32 register file.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; must be a power of 2 and at least 2.
- ADDR_W, 5, register address width; must equal log2(NREGS).
- NRD, 2, number of read ports; legal range 1..4.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- ra  in  NRD*ADDR_W  read addresses; port i uses ra[i*ADDR_W +: ADDR_W].
- rd  out  NRD*XLEN  read data; port i uses rd[i*XLEN +: XLEN].
- rbusy  out  NRD  bit i is high when port i's register has a pending producer not satisfied this cycle.
- we  in  1  write enable (WB stage).
- wa  in  ADDR_W  write address.
- wd  in  XLEN  write data.
- iss_v  in  1  an instruction with a destination issues this cycle.
- iss_rd  in  ADDR_W  destination register of the issuing instruction.
- flush  in  1  synchronous clear of all busy bits (pipeline flush).
- any_busy  out  1  OR of all busy bits.

Behaviour:
- Storage is NREGS x XLEN. Register 0 reads as 0, is never written, and is never busy. Writes or issues to address 0 are ignored.
- Reset (asynchronous): all registers clear to 0 and all busy bits clear to 0, immediately.
  - While rst is high: rd = 0 on every port (no bypass), rbusy = 0, any_busy = 0.
  - Reset takes priority over we, iss_v and flush in the same cycle.
- Read, per port i, fully combinational, zero latency:
  - ra_i == 0 -> 0.
  - Else if we and wa == ra_i -> wd (bypass).
  - Else -> stored value.
- Write: on the rising clock edge, if we and wa != 0, reg[wa] <= wd.
- Scoreboard update at the rising edge, applied in this order:
  1. If flush: all busy <= 0. iss_v in the same cycle is ignored.
  2. Else, if we and wa != 0: busy[wa] <= 0.
  3. Else-or-also, if iss_v and iss_rd != 0: busy[iss_rd] <= 1. Set wins over clear when iss_rd == wa in the same cycle, because the new producer supersedes the old one.
- rbusy_i = busy[ra_i] AND NOT (we AND wa == ra_i) AND ra_i != 0.
  - A register being written this cycle is not reported busy, since its data is bypassed.
  - rbusy reflects state before the current edge. An iss_v in the same cycle does not affect rbusy until the next cycle.
- Write to a non-busy register: legal. Data is updated and busy stays 0.
- Issue to an already-busy register: busy stays 1. There is a single busy bit per register, not a count.
- Multiple read ports may address the same register. Each port resolves independently and gives identical results.
- There are no X outputs after reset for any in-range address.

Test Plan:
1. Reset pulse mid-cycle with reg[5] = 0xDEADBEEF and busy[5] = 1 -> immediately rd(ra=5) = 0, rbusy = 0, any_busy = 0. This holds after rst is released.
2. we=1, wa=7, wd=0x12345678 with ra0=7 in the same cycle -> rd0 = 0x12345678 before the edge (bypass). Next cycle with we=0 -> rd0 = 0x12345678 from storage.
3. we=1, wa=0, wd=0xFFFFFFFF; iss_v=1, iss_rd=0 -> rd(ra=0) = 0, rbusy = 0, any_busy = 0 on all following cycles.
4. Issue iss_rd=3, then ra0=3:
   - Next cycle -> rbusy0 = 1, any_busy = 1.
   - Cycle with we=1, wa=3, wd=0xA5 -> rbusy0 = 0 and rd0 = 0xA5 in that cycle.
   - Following cycle -> busy[3] = 0 and any_busy = 0.
5. Busy[4] = 1, then the same edge carries we=1, wa=4 and iss_v=1, iss_rd=4 -> after the edge busy[4] = 1 and reg[4] = wd.
6. Busy set on registers 2, 9 and 31, then flush=1 with iss_v=1, iss_rd=10 -> after the edge any_busy = 0 and busy[10] = 0. Repeat with NRD=3 and XLEN=64, checking that all three ports return independent values for ra = {1, 2, 1}.
